// File: rtl/hadamard_pipe.sv
// hadamard_pipe: fully pipelined N-point Walsh-Hadamard transform with per-vector halving and valid/ready flow control
module hadamard_pipe #(
   parameter int DW    = 12,
   parameter int LOG2N = 2
) (
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic                              I_VALID,
   output logic                              I_READY,
   input  logic                              I_SCALE,
   input  logic [(DW<<LOG2N)-1:0]            I_DATA,
   output logic                              O_VALID,
   input  logic                              O_READY,
   output logic                              O_SCALE,
   output logic [((DW+LOG2N)<<LOG2N)-1:0]    O_DATA
);
   localparam int N  = 1 << LOG2N;
   localparam int OW = DW + LOG2N;

   logic                 adv;
   logic signed [OW-1:0] d [LOG2N+1][N];
   logic [LOG2N:0]       v;
   logic [LOG2N:0]       sc;

   assign adv     = ~O_VALID | O_READY;
   assign I_READY = adv;
   assign O_VALID = v[LOG2N];
   assign O_SCALE = sc[LOG2N];

   genvar s, i;
   generate
      for (s = 0; s <= LOG2N; s++) begin : g_st
         logic signed [OW-1:0] nx [N];
         logic signed [OW-1:0] q  [N];
         logic                 nv, ns, qv, qs;
         if (s == 0) begin : g_in
            assign nv = I_VALID;
            assign ns = I_SCALE;
            for (i = 0; i < N; i++) begin : g_el
               assign nx[i] = {{LOG2N{I_DATA[i*DW+DW-1]}}, I_DATA[i*DW +: DW]};
            end
         end else begin : g_bf
            assign nv = v[s-1];
            assign ns = sc[s-1];
            for (i = 0; i < N; i++) begin : g_el
               localparam int J = i ^ (1 << (s-1));
               logic signed [OW-1:0] t;
               assign t     = (((i >> (s-1)) & 1) == 0) ? d[s-1][i] + d[s-1][J] : d[s-1][J] - d[s-1][i];
               assign nx[i] = sc[s-1] ? t >>> 1 : t;
            end
         end
         // stage register: cleared by reset, moves only when the whole pipe can advance
         always_ff @(posedge CLK) begin
            if (RESET) begin
               qv <= 1'b0;
               qs <= 1'b0;
               for (int k = 0; k < N; k++) q[k] <= '0;
            end else if (adv) begin
               qv <= nv;
               qs <= ns;
               for (int k = 0; k < N; k++) q[k] <= nx[k];
            end
         end
         assign v[s]  = qv;
         assign sc[s] = qs;
         for (i = 0; i < N; i++) begin : g_q
            assign d[s][i] = q[i];
         end
      end
      for (i = 0; i < N; i++) begin : g_o
         assign O_DATA[i*OW +: OW] = d[LOG2N][i];
      end
   endgenerate
endmodule

// File: tb/tb_hadamard_pipe.sv
// tb_hadamard_pipe: directed and randomized checks of hadamard_pipe against a closed-form reference
module tb_hadamard_pipe;
   localparam int NSW = 6;
   localparam int SDW [NSW] = '{8, 8, 8, 16, 16, 16};
   localparam int SL  [NSW] = '{1, 3, 4, 1, 3, 4};

   logic          CLK;
   logic          RESET, I_VALID, I_READY, I_SCALE, O_VALID, O_READY, O_SCALE;
   logic [47:0]   I_DATA;
   logic [55:0]   O_DATA;
   logic          sw_valid, sw_scale;
   logic [255:0]  sw_in;
   logic [319:0]  sw_out [NSW];
   logic [NSW-1:0] sw_ov, sw_os, sw_ir;
   int            npass = 0, ntot = 0, nfail = 0;
   logic [320:0]  q [$];
   logic [320:0]  sq [NSW][$];
   logic          prev_stall;
   logic [56:0]   prev_out;
   logic [319:0]  ev;

   hadamard_pipe #(.DW(12), .LOG2N(2)) u_dut (
      .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .I_READY(I_READY), .I_SCALE(I_SCALE), .I_DATA(I_DATA),
      .O_VALID(O_VALID), .O_READY(O_READY), .O_SCALE(O_SCALE), .O_DATA(O_DATA)
   );

   for (genvar g = 0; g < NSW; g++) begin : g_sw
      localparam int W = SDW[g];
      localparam int L = SL[g];
      logic [((W+L)<<L)-1:0] od;
      hadamard_pipe #(.DW(W), .LOG2N(L)) u_sw (
         .CLK(CLK), .RESET(RESET), .I_VALID(sw_valid), .I_READY(sw_ir[g]), .I_SCALE(sw_scale),
         .I_DATA(sw_in[(W<<L)-1:0]), .O_VALID(sw_ov[g]), .O_READY(1'b1), .O_SCALE(sw_os[g]), .O_DATA(od)
      );
      assign sw_out[g] = 320'(od);
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // reference: closed-form sign sum when unscaled, staged halving with floor when scaled
   function automatic logic [319:0] expect_vec(input logic [255:0] bits, input int dw, input int l, input logic scl);
      int x [16];
      int y [16];
      int n, ow, p, m, j;
      logic [255:0] sh;
      logic [319:0] r;
      n = 1 << l;
      ow = dw + l;
      r = '0;
      for (int i = 0; i < n; i++) begin
         sh = bits >> (i * dw);
         x[i] = int'(sh[31:0]);
         x[i] = (x[i] <<< (32 - dw)) >>> (32 - dw);
      end
      if (!scl) begin
         for (int k = 0; k < n; k++) begin
            y[k] = 0;
            for (int t = 0; t < n; t++) y[k] += ($countones(k & t) % 2 == 1) ? -x[t] : x[t];
         end
      end else begin
         for (int i = 0; i < n; i++) y[i] = x[i];
         for (int s = 0; s < l; s++)
            for (int i = 0; i < n; i++)
               if (((i >> s) & 1) == 0) begin
                  j = i | (1 << s);
                  p = y[i] + y[j];
                  m = y[i] - y[j];
                  y[i] = p >>> 1;
                  y[j] = m >>> 1;
               end
      end
      for (int k = 0; k < n; k++)
         for (int b = 0; b < ow; b++) r[k*ow+b] = y[k][b];
      return r;
   endfunction

   function automatic logic [47:0] pk_in(input int a, input int b, input int c, input int e);
      return {12'(e), 12'(c), 12'(b), 12'(a)};
   endfunction

   function automatic logic [55:0] pk_out(input int a, input int b, input int c, input int e);
      return {14'(e), 14'(c), 14'(b), 14'(a)};
   endfunction

   function automatic logic [47:0] rnd48();
      return {16'($urandom()), 32'($urandom())};
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic chk(input string tag, input logic [320:0] obs, input logic [320:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: record handshakes that the coming edge performs, then step to the next falling edge
   task automatic tick();
      logic [320:0] e;
      #1;
      if (RESET) begin
         q.delete();
         for (int g = 0; g < NSW; g++) sq[g].delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("stall_hold", 321'({O_SCALE, O_DATA}), 321'(prev_out));
         if (O_VALID && !O_READY) chk("stall_iready", 321'(I_READY), 321'(0));
         if (O_VALID && O_READY) begin
            if (q.size() == 0) chk("spurious_out", 321'(O_VALID), 321'(0));
            else begin
               e = q.pop_front();
               chk("out", {O_SCALE, 320'(O_DATA)}, e);
            end
         end
         if (I_VALID && I_READY) q.push_back({I_SCALE, expect_vec(256'(I_DATA), 12, 2, I_SCALE)});
         for (int g = 0; g < NSW; g++) begin
            if (sw_ov[g]) begin
               if (sq[g].size() == 0) chk($sformatf("sweep%0d_spurious", g), 321'(sw_ov[g]), 321'(0));
               else begin
                  e = sq[g].pop_front();
                  chk($sformatf("sweep%0d", g), {sw_os[g], sw_out[g]}, e);
               end
            end
            if (sw_valid && sw_ir[g]) sq[g].push_back({sw_scale, expect_vec(sw_in, SDW[g], SL[g], sw_scale)});
         end
         prev_stall = O_VALID && !O_READY;
         prev_out = {O_SCALE, O_DATA};
      end
      @(negedge CLK);
   endtask

   task automatic send_check(input logic [47:0] x, input logic scl, input logic [55:0] y, input string tag);
      I_DATA = x;
      I_SCALE = scl;
      I_VALID = 1'b1;
      tick();
      I_VALID = 1'b0;
      tick();
      chk({tag, "_early"}, 321'(O_VALID), 321'(0));
      tick();
      chk({tag, "_valid"}, 321'(O_VALID), 321'(1));
      chk({tag, "_data"}, 321'({O_SCALE, O_DATA}), 321'({scl, y}));
   endtask

   initial begin
      logic [47:0] xv;
      RESET = 1'b1;
      I_VALID = 1'b1;
      I_SCALE = 1'b1;
      I_DATA = rnd48();
      O_READY = 1'b1;
      sw_valid = 1'b0;
      sw_scale = 1'b0;
      sw_in = '0;
      prev_stall = 1'b0;
      prev_out = '0;
      tick();
      I_DATA = rnd48();
      tick();
      chk("rst_ovalid", 321'(O_VALID), 321'(0));
      chk("rst_odata", 321'(O_DATA), 321'(0));
      chk("rst_oscale", 321'(O_SCALE), 321'(0));
      chk("rst_iready", 321'(I_READY), 321'(1));
      RESET = 1'b0;
      I_VALID = 1'b0;
      repeat (4) begin
         tick();
         chk("post_rst_idle", 321'(O_VALID), 321'(0));
      end
      send_check(pk_in(1, 2, 3, 4), 1'b0, pk_out(10, -2, -4, 0), "u1234");
      send_check(pk_in(2047, -2048, 2047, -2048), 1'b0, pk_out(-2, 8190, 0, 0), "uext");
      send_check(pk_in(-2048, -2048, -2048, -2048), 1'b0, pk_out(-8192, 0, 0, 0), "uneg");
      send_check(pk_in(1, 2, 3, 4), 1'b1, pk_out(2, -1, -1, 0), "s1234");
      send_check(pk_in(-2048, -2048, -2048, -2048), 1'b1, pk_out(-2048, 0, 0, 0), "sneg");
      for (int i = 0; i < 24; i++) begin
         I_VALID = (i < 20);
         I_SCALE = i[0];
         I_DATA = rnd48();
         tick();
         chk("stream_valid", 321'(O_VALID), 321'(i >= 2 && i < 22));
      end
      I_VALID = 1'b1;
      for (int i = 0; i < 60; i++) begin
         O_READY = (i >= 4 && i < 7) ? 1'b0 : 1'($urandom_range(0, 1));
         I_SCALE = 1'($urandom_range(0, 1));
         I_DATA = rnd48();
         tick();
      end
      O_READY = 1'b1;
      I_VALID = 1'b0;
      repeat (5) tick();
      chk("bp_drain", 321'(q.size()), 321'(0));
      I_VALID = 1'b1;
      I_DATA = rnd48();
      tick();
      I_DATA = rnd48();
      tick();
      I_VALID = 1'b0;
      RESET = 1'b1;
      tick();
      chk("midrst_ovalid", 321'(O_VALID), 321'(0));
      RESET = 1'b0;
      repeat (4) begin
         tick();
         chk("midrst_idle", 321'(O_VALID), 321'(0));
      end
      xv = rnd48();
      ev = expect_vec(256'(xv), 12, 2, 1'b0);
      send_check(xv, 1'b0, ev[55:0], "midrst_lat");
      for (int i = 0; i < 30; i++) begin
         sw_valid = 1'b1;
         sw_scale = 1'($urandom_range(0, 1));
         sw_in = rnd256();
         tick();
      end
      sw_valid = 1'b0;
      repeat (7) tick();
      for (int g = 0; g < NSW; g++) chk($sformatf("sweep%0d_drain", g), 321'(sq[g].size()), 321'(0));
      chk("final_drain", 321'(q.size()), 321'(0));
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
